// File: rtl/sgd_model_wr_ctrl_pkg.sv
// Shared definitions for the SGD model write controller: FSM state
// encodings, error codes and default datapath widths.
package sgd_model_wr_ctrl_pkg;

  localparam int SGD_DATA_W = 256;
  localparam int SGD_ADDR_W = 12;

  // Encoding is visible to software through status[30:28].
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_INIT   = 3'd1,
    ST_EPOCH  = 3'd2,
    ST_CHECK  = 3'd3,
    ST_SKIP   = 3'd4,
    ST_UPDATE = 3'd5,
    ST_GLOBAL = 3'd6,
    ST_FINISH = 3'd7
  } state_e;

  localparam logic [3:0] ERR_OK        = 4'd0;
  localparam logic [3:0] ERR_DIM       = 4'd1;
  localparam logic [3:0] ERR_BATCH     = 4'd2;
  localparam logic [3:0] ERR_UPD_CHECK = 4'd3;

endpackage

// File: rtl/sgd_model_wr_ctrl_credit_delay.sv
// Fixed-depth delay line for the 8-bit credit count, so the credit the
// A*x reader sees lags the internal grant by DEPTH cycles.
module sgd_model_wr_ctrl_credit_delay #(
  parameter int DEPTH = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] i_credit,
  output logic [7:0] o_credit
);

  logic [7:0] r_pipe [DEPTH];

  // Shift the internal credit value through DEPTH stages.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_pipe[i] <= 8'd0;
    end else begin
      r_pipe[0] <= i_credit;
      for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign o_credit = r_pipe[DEPTH-1];

endmodule

// File: rtl/sgd_model_wr_ctrl.sv
// Gates per-chunk model updates into the x BRAM once per mini-batch,
// grants read credits to the A*x reader and requests host write-back at
// epoch end.
// Build option SGD_MODEL_WR_CHAIN_EN: grant the next batch's credit at
// the first chunk of an update window instead of at its end, so the next
// batch's reads overlap the model write.
module sgd_model_wr_ctrl
  import sgd_model_wr_ctrl_pkg::*;
#(
  parameter int DATA_W     = SGD_DATA_W,
  parameter int ADDR_W     = SGD_ADDR_W,
  parameter int BANK_LOG2  = 3,
  parameter int CREDIT_DLY = 5,
  parameter int CNT_W      = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic [31:0]       i_cfg_dimension,
  input  logic [31:0]       i_cfg_batch,
  input  logic [31:0]       i_cfg_epochs,
  input  logic [31:0]       i_cfg_samples,
  input  logic              i_upd_valid,
  input  logic [ADDR_W-1:0] i_upd_addr,
  input  logic [DATA_W-1:0] i_upd_data,
  output logic              o_x_wr_en,
  output logic [ADDR_W-1:0] o_x_wr_addr,
  output logic [DATA_W-1:0] o_x_wr_data,
  output logic [7:0]        o_credit,
  output logic              o_host_wr_en,
  input  logic              i_host_wr_done,
  output logic              o_done,
  output logic              o_error,
  output logic [3:0]        o_err_code,
  output logic [31:0]       o_status
);

  localparam logic [32:0] LP_ROUND = 33'((1 << BANK_LOG2) - 1);
  localparam logic [31:0] LP_STEP  = 32'(1 << BANK_LOG2);

  state_e              r_state;
  logic                r_start_r1;
  logic                r_start_r2;
  logic [31:0]         r_dim;
  logic [31:0]         r_batch;
  logic [9:0]          r_epochs;
  logic [31:0]         r_samples;
  logic [9:0]          r_epoch_idx;
  logic [31:0]         r_sample_idx;
  logic [31:0]         r_batch_idx;
  logic [CNT_W-1:0]    r_chunk_idx;
  logic                r_last_batch;
  logic [7:0]          r_credit;
  logic                r_s1_valid;
  logic [ADDR_W-1:0]   r_s1_addr;
  logic [DATA_W-1:0]   r_s1_data;

  logic [32:0]         w_chunks;
  logic [31:0]         w_bbs;
  logic                w_last_step;
  logic                w_chunks_hit;
  logic                w_batch_hit;
  logic                w_upd_window;
  logic                w_unused;

  assign w_chunks     = ({1'b0, r_dim} + LP_ROUND) >> BANK_LOG2;
  assign w_bbs        = r_batch >> BANK_LOG2;
  assign w_last_step  = ({1'b0, r_sample_idx} + {1'b0, LP_STEP}) >= {1'b0, r_samples};
  assign w_chunks_hit = ({{(33-CNT_W){1'b0}}, r_chunk_idx} == w_chunks);
  assign w_batch_hit  = (r_batch_idx == (w_bbs - 32'd1));
  assign w_upd_window = (r_state == ST_UPDATE);
  assign w_unused     = ^i_cfg_epochs[31:10];

  assign o_status = {i_upd_valid, r_state, r_sample_idx[19:0], r_epoch_idx[7:0]};

  // Update path: one register stage, then the gated BRAM write port.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_valid  <= 1'b0;
      r_s1_addr   <= '0;
      r_s1_data   <= '0;
      o_x_wr_en   <= 1'b0;
      o_x_wr_addr <= '0;
      o_x_wr_data <= '0;
    end else begin
      r_s1_valid  <= i_upd_valid;
      r_s1_addr   <= i_upd_addr;
      r_s1_data   <= i_upd_data;
      o_x_wr_en   <= r_s1_valid & w_upd_window;
      o_x_wr_addr <= r_s1_addr;
      o_x_wr_data <= r_s1_data;
    end
  end

  // Run sequencing: config capture, batch/epoch walk, credits, host handshake.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_start_r1   <= 1'b0;
      r_start_r2   <= 1'b0;
      r_dim        <= '0;
      r_batch      <= '0;
      r_epochs     <= '0;
      r_samples    <= '0;
      r_epoch_idx  <= '0;
      r_sample_idx <= '0;
      r_batch_idx  <= '0;
      r_chunk_idx  <= '0;
      r_last_batch <= 1'b0;
      r_credit     <= 8'd0;
      o_host_wr_en <= 1'b0;
      o_done       <= 1'b0;
      o_error      <= 1'b0;
      o_err_code   <= ERR_OK;
    end else begin
      r_start_r1 <= i_start;
      r_start_r2 <= r_start_r1;
      case (r_state)
        ST_IDLE: begin
          r_dim     <= i_cfg_dimension;
          r_batch   <= i_cfg_batch;
          r_epochs  <= i_cfg_epochs[9:0];
          r_samples <= i_cfg_samples;
          if (r_start_r2) r_state <= ST_INIT;
        end
        ST_INIT: begin
          r_dim     <= i_cfg_dimension;
          r_batch   <= i_cfg_batch;
          r_epochs  <= i_cfg_epochs[9:0];
          r_samples <= i_cfg_samples;
          if (r_dim == 32'd0) begin
            o_error    <= 1'b1;
            o_err_code <= ERR_DIM;
            o_done     <= 1'b1;
            r_state    <= ST_FINISH;
          end else if ((r_batch == 32'd0) || (r_batch[BANK_LOG2-1:0] != '0)) begin
            o_error    <= 1'b1;
            o_err_code <= ERR_BATCH;
            o_done     <= 1'b1;
            r_state    <= ST_FINISH;
          end else begin
            r_state <= ST_EPOCH;
          end
        end
        ST_EPOCH: begin
          if (r_epoch_idx == r_epochs) begin
            o_done  <= 1'b1;
            r_state <= ST_FINISH;
          end else begin
            r_sample_idx <= '0;
            r_batch_idx  <= '0;
            r_chunk_idx  <= '0;
            // First batch of the run is pre-granted; later epochs get theirs from GLOBAL.
            if (r_epoch_idx == 10'd0) r_credit <= r_credit + w_bbs[7:0];
            r_state <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          r_sample_idx <= r_sample_idx + LP_STEP;
          r_batch_idx  <= r_batch_idx + 32'd1;
          if (r_s1_valid) begin
            o_error    <= 1'b1;
            o_err_code <= ERR_UPD_CHECK;
            o_done     <= 1'b1;
            r_state    <= ST_FINISH;
          end else if (r_sample_idx >= r_samples) begin
            o_host_wr_en <= 1'b1;
            r_state      <= ST_GLOBAL;
          end else if (w_batch_hit || w_last_step) begin
            r_last_batch <= w_last_step;
            r_state      <= ST_UPDATE;
          end else begin
            r_state <= ST_SKIP;
          end
        end
        ST_SKIP: begin
          if (w_chunks_hit) begin
            r_chunk_idx <= '0;
            r_state     <= ST_CHECK;
          end else begin
            r_chunk_idx <= r_chunk_idx + CNT_W'(r_s1_valid);
          end
        end
        ST_UPDATE: begin
`ifdef SGD_MODEL_WR_CHAIN_EN
          if (r_s1_valid && (r_chunk_idx == '0) && !r_last_batch)
            r_credit <= r_credit + w_bbs[7:0];
`endif
          if (w_chunks_hit) begin
`ifndef SGD_MODEL_WR_CHAIN_EN
            if (!r_last_batch) r_credit <= r_credit + w_bbs[7:0];
`endif
            r_chunk_idx <= '0;
            r_batch_idx <= '0;
            r_state     <= ST_CHECK;
          end else begin
            r_chunk_idx <= r_chunk_idx + CNT_W'(r_s1_valid);
          end
        end
        ST_GLOBAL: begin
          if (i_host_wr_done) begin
            o_host_wr_en <= 1'b0;
            r_credit     <= r_credit + w_bbs[7:0];
            r_epoch_idx  <= r_epoch_idx + 10'd1;
            r_state      <= ST_EPOCH;
          end
        end
        ST_FINISH: begin
          o_done <= 1'b1;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  sgd_model_wr_ctrl_credit_delay #(
    .DEPTH (CREDIT_DLY)
  ) u_credit_dly (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_credit (r_credit),
    .o_credit (o_credit)
  );

endmodule
